arm7tdmi_shift_stage: RTL and testbench
=======================================

ARM7TDMI_SHIFT_STAGE -- requirements
Module: arm7tdmi_shift_stage

Interface
REQ-001 SHALL have port: clk  input  1  rising-edge clock; the only clock.
REQ-002 SHALL have port: rst_n  input  1  reset, synchronous, active-low.
REQ-003 SHALL have port: in_valid  input  1  upstream operand request valid.
REQ-004 SHALL have port: in_ready  output  1  stage can accept a request this cycle.
REQ-005 SHALL have port: rm_value  input  32  value to shift (Rm), or imm8 in bits [7:0] when imm_mode=1.
REQ-006 SHALL have port: shift_type  input  2  00 LSL, 01 LSR, 10 ASR, 11 ROR.
REQ-007 SHALL have port: shift_imm  input  5  immediate shift amount; bits [3:0] are the rotate field when imm_mode=1.
REQ-008 SHALL have port: shift_by_reg  input  1  amount comes from rs_value[7:0].
REQ-009 SHALL have port: rs_value  input  8  register shift amount (low byte of Rs).
REQ-010 SHALL have port: imm_mode  input  1  rotated-immediate operand; overrides shift_by_reg.
REQ-011 SHALL have port: carry_in  input  1  current CPSR C.
REQ-012 SHALL have port: out_valid  output  1  operand_b/shifter_carry valid for the ALU.
REQ-013 SHALL have port: out_ready  input  1  ALU consumes the result this cycle.
REQ-014 SHALL have port: operand_b  output  32  shifted operand to the ALU operand_b.
REQ-015 SHALL have port: shifter_carry  output  1  shifter carry to the ALU carry_in for logical ops.

Function
REQ-016 SHALL accept a request when in_valid && in_ready; all request inputs are sampled on that edge only.
REQ-017 SHALL drive in_ready = (state==IDLE) && (!out_valid || out_ready), combinationally.
REQ-018 SHALL implement FSM IDLE/RS_WAIT: IDLE->RS_WAIT on accept with shift_by_reg=1 and imm_mode=0; RS_WAIT->IDLE unconditionally next cycle; all other accepts stay in IDLE.
REQ-019 SHALL register results: out_valid rises 1 cycle after accept (immediate/imm_mode) or 2 cycles after accept (register shift).
REQ-020 SHALL hold operand_b, shifter_carry, out_valid stable while out_valid && !out_ready; clear out_valid on out_ready when no new result lands that edge.
REQ-021 SHALL allow back-to-back: accept in the cycle out_ready=1 yields a new result on the next edge, no bubble (immediate path).
REQ-022 Immediate LSL #0: result=rm, carry=carry_in; LSL #n: carry=rm[32-n].
REQ-023 Immediate LSR #0 SHALL mean LSR #32: result 0, carry rm[31]; ASR #0 means ASR #32: result all rm[31], carry rm[31].
REQ-024 Immediate ROR #0 SHALL mean RRX: result {carry_in, rm[31:1]}, carry rm[0].
REQ-025 Register shift amount 0 SHALL pass rm unchanged, carry=carry_in, for all types.
REQ-026 Register LSL: 32 -> 0, carry rm[0]; >32 -> 0, carry 0. LSR: 32 -> 0, carry rm[31]; >32 -> 0, carry 0.
REQ-027 Register ASR >=32 SHALL give all rm[31], carry rm[31].
REQ-028 Register ROR: amount[4:0]==0 (nonzero) -> result rm, carry rm[31]; else rotate by amount[4:0], carry = result[31].
REQ-029 imm_mode SHALL give ror(zero-extended imm8, 2*rot); carry = carry_in if rot==0, else result[31].

Reset
REQ-030 On rst_n=0 at a clock edge: state=IDLE, out_valid=0, operand_b=0, shifter_carry=0.
REQ-031 Reset in RS_WAIT or with out_valid=1 SHALL discard the pending operation; no output after release until a new accept.
REQ-032 in_ready SHALL be 0 while rst_n=0.

Configuration
REQ-033 Macro ARM7TDMI_RS_ICYCLE_EN defined: register shifts use RS_WAIT (2-cycle latency, in_ready low in RS_WAIT).
REQ-034 Macro undefined: RS_WAIT removed, register shifts complete with 1-cycle latency like immediates; results identical.

Verification
REQ-035 rm=0x80000001, LSR imm 0, carry_in=0 -> next cycle operand_b=0x00000000, shifter_carry=1.
REQ-036 rm=0x00000003, ROR imm 0, carry_in=1 -> operand_b=0x80000001, shifter_carry=1.
REQ-037 rm=0x00000001, LSL by reg rs=32 -> operand_b=0, carry=1; rs=33 -> 0, carry 0; with macro out_valid 2 cycles after accept, in_ready=0 in between.
REQ-038 imm_mode, imm8=0xFF, rot=4, carry_in=0 -> operand_b=0xFF000000, shifter_carry=1; rot=0, carry_in=1 -> 0x000000FF, carry 1.
REQ-039 Hold out_ready=0 for 3 cycles after result -> operand_b/carry/out_valid stable, in_ready=0; raise out_ready with new in_valid -> next result next cycle.
REQ-040 Assert rst_n=0 in RS_WAIT -> after release out_valid=0, in_ready=1, no stale result emitted.

Source files
------------

// File: rtl/arm7tdmi_shift_stage.sv
// Purpose: ARM7TDMI barrel-shifter stage producing operand_b and shifter carry for the ALU.
// Latency: 1 cycle for immediate/rotated-immediate; register shifts take 2 cycles when ARM7TDMI_RS_ICYCLE_EN is defined, else 1.
// Backpressure: result held while out_valid && !out_ready; in_ready low while a result is stalled or in RS_WAIT.
module arm7tdmi_shift_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] rm_value,
    input  logic [1:0]  shift_type,
    input  logic [4:0]  shift_imm,
    input  logic        shift_by_reg,
    input  logic [7:0]  rs_value,
    input  logic        imm_mode,
    input  logic        carry_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] operand_b,
    output logic        shifter_carry
);

    localparam logic [1:0] SH_LSL = 2'b00;
    localparam logic [1:0] SH_LSR = 2'b01;
    localparam logic [1:0] SH_ASR = 2'b10;
    localparam logic [1:0] SH_ROR = 2'b11;

    typedef enum logic {
        IDLE    = 1'b0,
        RS_WAIT = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic        out_valid_q;
    logic [31:0] operand_b_q;
    logic        shifter_carry_q;

    logic        accept;
    logic        load_res;
    logic [32:0] res_now;
    logic [32:0] res_sel;

`ifdef ARM7TDMI_RS_ICYCLE_EN
    // Register-shift operands captured at accept; consumed in RS_WAIT.
    logic [31:0] rm_q;
    logic [1:0]  type_q;
    logic [7:0]  rs_q;
    logic        cin_q;
    logic [32:0] res_rs;
`endif

    // Returns {carry, result}. The wide shifts carry the last bit shifted out
    // in the extra bit position, so ARM's out-of-range amounts (32, >32) fall
    // out of the ordinary shift semantics without extra comparators.
    function automatic logic [32:0] shift_calc(
        input logic [31:0] rm,
        input logic [1:0]  st,
        input logic [4:0]  simm,
        input logic        by_reg,
        input logic [7:0]  rs,
        input logic        imm,
        input logic        cin
    );
        logic [7:0]  amt;
        logic [32:0] lsl_w;
        logic [32:0] lsr_w;
        logic [32:0] asr_w;
        logic [63:0] ror_w;
        logic [63:0] imm_w;
        logic [32:0] res;
        amt   = 8'd0;
        lsl_w = 33'd0;
        lsr_w = 33'd0;
        asr_w = 33'd0;
        ror_w = 64'd0;
        imm_w = 64'd0;
        res   = {cin, rm};
        if (imm) begin
            // imm8 rotated right by twice the 4-bit rotate field
            imm_w = {24'd0, rm[7:0], 24'd0, rm[7:0]} >> {simm[3:0], 1'b0};
            res   = {(simm[3:0] == 4'd0) ? cin : imm_w[31], imm_w[31:0]};
        end else begin
            amt = by_reg ? rs : {3'd0, simm};
            // Immediate LSR #0 / ASR #0 encode a shift by 32
            if (!by_reg && (simm == 5'd0) && ((st == SH_LSR) || (st == SH_ASR))) begin
                amt = 8'd32;
            end
            lsl_w = {1'b0, rm} << amt;
            lsr_w = {rm, 1'b0} >> amt;
            asr_w = 33'($signed({rm, 1'b0}) >>> amt);
            ror_w = {rm, rm} >> amt[4:0];
            if (amt == 8'd0) begin
                res = {cin, rm};
            end else begin
                case (st)
                    SH_LSL:  res = lsl_w;
                    SH_LSR:  res = {lsr_w[0], lsr_w[32:1]};
                    SH_ASR:  res = {asr_w[0], asr_w[32:1]};
                    default: res = {ror_w[31], ror_w[31:0]};
                endcase
            end
            // Immediate ROR #0 encodes RRX
            if (!by_reg && (simm == 5'd0) && (st == SH_ROR)) begin
                res = {rm[0], cin, rm[31:1]};
            end
        end
        return res;
    endfunction

    // Shift result computed straight from the request inputs.
    always_comb begin
        res_now = shift_calc(rm_value, shift_type, shift_imm, shift_by_reg,
                             rs_value, imm_mode, carry_in);
    end

`ifdef ARM7TDMI_RS_ICYCLE_EN
    // Shift result for a register shift, from the operands captured at accept.
    always_comb begin
        res_rs = shift_calc(rm_q, type_q, 5'd0, 1'b1, rs_q, 1'b0, cin_q);
    end

    // Capture register-shift operands; datapath only, no reset needed.
    always_ff @(posedge clk) begin
        if (accept) begin
            rm_q   <= rm_value;
            type_q <= shift_type;
            rs_q   <= rs_value;
            cin_q  <= carry_in;
        end
    end
`endif

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: register shifts take the extra Rs-read cycle when enabled.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
`ifdef ARM7TDMI_RS_ICYCLE_EN
                if (accept && shift_by_reg && !imm_mode) begin
                    state_d = RS_WAIT;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: handshake, result-load strobe and result source select.
    always_comb begin
        in_ready = rst_n && (state_q == IDLE) && (!out_valid_q || out_ready);
        accept   = in_valid && in_ready;
`ifdef ARM7TDMI_RS_ICYCLE_EN
        load_res = (accept && !(shift_by_reg && !imm_mode)) || (state_q == RS_WAIT);
        res_sel  = (state_q == RS_WAIT) ? res_rs : res_now;
`else
        load_res = accept;
        res_sel  = res_now;
`endif
    end

    // Output register: load a new result, otherwise hold until consumed.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q     <= 1'b0;
            operand_b_q     <= 32'd0;
            shifter_carry_q <= 1'b0;
        end else if (load_res) begin
            out_valid_q     <= 1'b1;
            operand_b_q     <= res_sel[31:0];
            shifter_carry_q <= res_sel[32];
        end else if (out_ready) begin
            out_valid_q     <= 1'b0;
        end
    end

    assign out_valid     = out_valid_q;
    assign operand_b     = operand_b_q;
    assign shifter_carry = shifter_carry_q;

endmodule

// File: tb/tb_arm7tdmi_shift_stage.sv
// Bench for arm7tdmi_shift_stage: directed requests, reference model feeding a result queue.
// Results are checked when the DUT presents them; latency follows ARM7TDMI_RS_ICYCLE_EN.
// Stalls, back-to-back streaming and reset during a pending operation are exercised.
module tb_arm7tdmi_shift_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] rm_value;
    logic [1:0]  shift_type;
    logic [4:0]  shift_imm;
    logic        shift_by_reg;
    logic [7:0]  rs_value;
    logic        imm_mode;
    logic        carry_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] operand_b;
    logic        shifter_carry;

    typedef struct {
        logic [31:0] rm;
        logic [1:0]  st;
        logic [4:0]  si;
        logic        br;
        logic [7:0]  rs;
        logic        im;
        logic        cin;
    } req_t;

    int          checks = 0;
    int          errors = 0;
    logic [32:0] exp_q[$];
    req_t        tbl[$];

    arm7tdmi_shift_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .rm_value      (rm_value),
        .shift_type    (shift_type),
        .shift_imm     (shift_imm),
        .shift_by_reg  (shift_by_reg),
        .rs_value      (rs_value),
        .imm_mode      (imm_mode),
        .carry_in      (carry_in),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .operand_b     (operand_b),
        .shifter_carry (shifter_carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Bit-serial reference: shifts one position at a time, tracking the last bit out.
    function automatic logic [32:0] ref_shift(input req_t q);
        logic [31:0] r;
        logic        c;
        int          n;
        if (q.im) begin
            r = {24'd0, q.rm[7:0]};
            for (int i = 0; i < 2 * int'(q.si[3:0]); i++) r = {r[0], r[31:1]};
            c = (q.si[3:0] == 4'd0) ? q.cin : r[31];
            return {c, r};
        end
        r = q.rm;
        c = q.cin;
        n = q.br ? int'(q.rs) : int'(q.si);
        if (n == 0) begin
            if (q.br || q.st == 2'b00) return {c, r};
            if (q.st == 2'b11) return {q.rm[0], q.cin, q.rm[31:1]};
            n = 32;
        end
        if (q.st == 2'b11 && q.br) begin
            n = n % 32;
            if (n == 0) return {q.rm[31], q.rm};
        end
        for (int i = 0; i < n; i++) begin
            case (q.st)
                2'b00:   begin c = r[31]; r = r << 1; end
                2'b01:   begin c = r[0];  r = r >> 1; end
                2'b10:   begin c = r[0];  r = {r[31], r[31:1]}; end
                default: begin c = r[0];  r = {r[0], r[31:1]}; end
            endcase
        end
        return {c, r};
    endfunction

    task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input req_t q);
        rm_value     = q.rm;
        shift_type   = q.st;
        shift_imm    = q.si;
        shift_by_reg = q.br;
        rs_value     = q.rs;
        imm_mode     = q.im;
        carry_in     = q.cin;
    endtask

    // Present a request, wait (bounded) for acceptance, optionally queue the expected result.
    task automatic send(input req_t q, input bit push);
        int n;
        drive(q);
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin
            step();
            n++;
        end
        check("accept in_ready", {32'd0, in_ready}, 33'd1);
        if (in_ready) begin
            if (push) exp_q.push_back(ref_shift(q));
            step();
        end
        in_valid = 1'b0;
    endtask

    // Wait (bounded) for a result, compare against the queue head, then consume it.
    task automatic collect(input string tag);
        int n;
        n = 0;
        while (!out_valid && n < 10) begin
            step();
            n++;
        end
        check({tag, " out_valid"}, {32'd0, out_valid}, 33'd1);
        if (exp_q.size() == 0) begin
            check({tag, " queue"}, 33'd0, 33'd1);
        end else begin
            check({tag, " result"}, {shifter_carry, operand_b}, exp_q.pop_front());
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    // After accepting a register shift: extra cycle with in_ready low only when RS_WAIT exists.
    task automatic reg_latency(input string tag);
`ifdef ARM7TDMI_RS_ICYCLE_EN
        check({tag, " rs_wait out_valid"}, {32'd0, out_valid}, 33'd0);
        check({tag, " rs_wait in_ready"}, {32'd0, in_ready}, 33'd0);
        step();
`endif
        check({tag, " latency"}, {32'd0, out_valid}, 33'd1);
    endtask

    initial begin
        req_t q;
        logic [32:0] held;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        drive('{32'h0, 2'b00, 5'd0, 1'b0, 8'd0, 1'b0, 1'b0});

        // Reset state
        step();
        step();
        check("reset in_ready", {32'd0, in_ready}, 33'd0);
        check("reset out_valid", {32'd0, out_valid}, 33'd0);
        check("reset outputs", {shifter_carry, operand_b}, 33'd0);
        rst_n = 1'b1;
        #1;
        check("post-reset in_ready", {32'd0, in_ready}, 33'd1);

        // LSR #0 means LSR #32
        send('{32'h8000_0001, 2'b01, 5'd0, 1'b0, 8'd0, 1'b0, 1'b0}, 1);
        check("lsr0 latency", {32'd0, out_valid}, 33'd1);
        check("lsr0 value", {shifter_carry, operand_b}, {1'b1, 32'h0000_0000});
        collect("lsr0");

        // ROR #0 means RRX
        send('{32'h0000_0003, 2'b11, 5'd0, 1'b0, 8'd0, 1'b0, 1'b1}, 1);
        check("rrx value", {shifter_carry, operand_b}, {1'b1, 32'h8000_0001});
        collect("rrx");

        // Register LSL by 32 and 33
        send('{32'h0000_0001, 2'b00, 5'd0, 1'b1, 8'd32, 1'b0, 1'b0}, 1);
        reg_latency("lsl32");
        check("lsl32 value", {shifter_carry, operand_b}, {1'b1, 32'h0});
        collect("lsl32");
        send('{32'h0000_0001, 2'b00, 5'd0, 1'b1, 8'd33, 1'b0, 1'b1}, 1);
        reg_latency("lsl33");
        check("lsl33 value", {shifter_carry, operand_b}, {1'b0, 32'h0});
        collect("lsl33");

        // Rotated immediates
        send('{32'h0000_00FF, 2'b00, 5'd4, 1'b0, 8'd0, 1'b1, 1'b0}, 1);
        check("imm rot4 value", {shifter_carry, operand_b}, {1'b1, 32'hFF00_0000});
        collect("imm rot4");
        send('{32'h0000_00FF, 2'b00, 5'd0, 1'b0, 8'd0, 1'b1, 1'b1}, 1);
        check("imm rot0 value", {shifter_carry, operand_b}, {1'b1, 32'h0000_00FF});
        collect("imm rot0");

        // Boundary table: immediates, register amounts 0/32/>32/multiples of 32, imm_mode
        tbl.push_back('{32'h8000_0001, 2'b00, 5'd1,  1'b0, 8'd0,   1'b0, 1'b0});
        tbl.push_back('{32'hF000_000F, 2'b01, 5'd4,  1'b0, 8'd0,   1'b0, 1'b0});
        tbl.push_back('{32'h8000_0000, 2'b10, 5'd0,  1'b0, 8'd0,   1'b0, 1'b0});
        tbl.push_back('{32'h1234_5678, 2'b11, 5'd8,  1'b0, 8'd0,   1'b0, 1'b0});
        tbl.push_back('{32'h0000_00F0, 2'b00, 5'd0,  1'b0, 8'd0,   1'b0, 1'b1});
        tbl.push_back('{32'hDEAD_BEEF, 2'b01, 5'd0,  1'b1, 8'd0,   1'b0, 1'b1});
        tbl.push_back('{32'h8000_0000, 2'b01, 5'd0,  1'b1, 8'd32,  1'b0, 1'b0});
        tbl.push_back('{32'hFFFF_FFFF, 2'b01, 5'd0,  1'b1, 8'd40,  1'b0, 1'b1});
        tbl.push_back('{32'h8000_0000, 2'b10, 5'd0,  1'b1, 8'd200, 1'b0, 1'b0});
        tbl.push_back('{32'h7000_0000, 2'b10, 5'd0,  1'b1, 8'd32,  1'b0, 1'b1});
        tbl.push_back('{32'h8000_0001, 2'b11, 5'd0,  1'b1, 8'd64,  1'b0, 1'b0});
        tbl.push_back('{32'h0000_0003, 2'b11, 5'd0,  1'b1, 8'd33,  1'b0, 1'b0});
        tbl.push_back('{32'h0000_0010, 2'b10, 5'd0,  1'b1, 8'd4,   1'b0, 1'b1});
        tbl.push_back('{32'h0000_00AB, 2'b10, 5'h1F, 1'b1, 8'd7,   1'b1, 1'b0});
        for (int i = 0; i < 8; i++) begin
            q.rm  = $urandom;
            q.st  = 2'($urandom_range(0, 3));
            q.si  = 5'($urandom_range(0, 31));
            q.br  = 1'($urandom_range(0, 1));
            q.rs  = 8'($urandom_range(0, 255));
            q.im  = 1'($urandom_range(0, 3) == 0);
            q.cin = 1'($urandom_range(0, 1));
            tbl.push_back(q);
        end
        foreach (tbl[i]) begin
            send(tbl[i], 1);
            if (tbl[i].br && !tbl[i].im) reg_latency($sformatf("tbl%0d", i));
            else check($sformatf("tbl%0d latency", i), {32'd0, out_valid}, 33'd1);
            collect($sformatf("tbl%0d", i));
        end

        // Stall: result held for 3 cycles with out_ready low
        send('{32'h0000_00FF, 2'b00, 5'd4, 1'b0, 8'd0, 1'b0, 1'b0}, 1);
        held = exp_q[0];
        for (int i = 0; i < 3; i++) begin
            check($sformatf("hold%0d out_valid", i), {32'd0, out_valid}, 33'd1);
            check($sformatf("hold%0d in_ready", i), {32'd0, in_ready}, 33'd0);
            check($sformatf("hold%0d value", i), {shifter_carry, operand_b}, held);
            step();
        end
        void'(exp_q.pop_front());
        out_ready = 1'b1;
        send('{32'h8000_0000, 2'b10, 5'd3, 1'b0, 8'd0, 1'b0, 1'b0}, 1);
        check("release latency", {32'd0, out_valid}, 33'd1);
        collect("release");
        check("drained out_valid", {32'd0, out_valid}, 33'd0);

        // Back-to-back immediates with out_ready held high
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            q = '{32'hA5A5_0000 + 32'(i), 2'(i), 5'(3 * i + 1), 1'b0, 8'd0, 1'b0, 1'(i)};
            drive(q);
            in_valid = 1'b1;
            #1;
            check($sformatf("b2b%0d in_ready", i), {32'd0, in_ready}, 33'd1);
            exp_q.push_back(ref_shift(q));
            step();
            check($sformatf("b2b%0d out_valid", i), {32'd0, out_valid}, 33'd1);
            check($sformatf("b2b%0d value", i), {shifter_carry, operand_b}, exp_q.pop_front());
        end
        in_valid = 1'b0;
        step();
        check("b2b drain", {32'd0, out_valid}, 33'd0);
        out_ready = 1'b0;

        // Reset while a register shift is pending
        send('{32'h0000_0001, 2'b00, 5'd0, 1'b1, 8'd8, 1'b0, 1'b0}, 0);
        rst_n = 1'b0;
        #1;
        check("rst in_ready low", {32'd0, in_ready}, 33'd0);
        step();
        rst_n = 1'b1;
        #1;
        check("rst out_valid", {32'd0, out_valid}, 33'd0);
        check("rst in_ready", {32'd0, in_ready}, 33'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("rst no stale %0d", i), {32'd0, out_valid}, 33'd0);
        end

        // Operation after reset recovery
        send('{32'h0000_0002, 2'b00, 5'd0, 1'b1, 8'd3, 1'b0, 1'b0}, 1);
        reg_latency("post-rst");
        collect("post-rst");

        check("queue empty", 33'(exp_q.size()), 33'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
